branch_pht: RTL

- Pattern History Table that supplies the 2-bit prediction (PHT_in) consumed by the IF-stage next-PC select logic.
- Holds 2^IDX_BITS two-bit saturating counters, indexed gshare-style: PC word bits XOR a global history register (GHR).
- Counters and GHR are trained when a conditional branch resolves in ID.
- Also keeps branch and mispredict performance counters for the test harness.

---
 rtl/branch_pht_pkg.sv | 9 +
 rtl/branch_pht_sat_counter2.sv | 17 +
 rtl/branch_pht.sv | 62 ++++++
 3 files changed

// File: rtl/branch_pht_pkg.sv
// branch_pht_pkg: shared counter encodings and branch opcode for the predictor and IF select logic
package branch_pht_pkg;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam int PHT_TAKEN_BIT = 1;
endpackage

// File: rtl/branch_pht_sat_counter2.sv
// pht_sat_counter2: 2-bit saturating up/down counter with async reset to INIT_STATE
module pht_sat_counter2
  import branch_pht_pkg::*;
#(
  parameter logic [1:0] INIT_STATE = WNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  output logic [1:0] q
);
  // count toward ST on taken and toward SNT on not-taken, holding at the ends
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= INIT_STATE;
    else if (en) q <= up ? (q == ST ? q : q + 2'd1) : (q == SNT ? q : q - 2'd1);
endmodule

// File: rtl/branch_pht.sv
// branch_pht: gshare-indexed table of 2-bit counters with global history and perf counters
module branch_pht
  import branch_pht_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int GHR_BITS = 4,
  parameter logic [1:0] INIT_STATE = WNT,
  localparam int GW = (GHR_BITS > 0) ? GHR_BITS : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                CE,
  input  logic [31:0]         if_pc,
  output logic [1:0]          pht_out,
  output logic [IDX_BITS-1:0] pred_idx,
  input  logic                upd_en,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken,
  input  logic                upd_mispred,
  output logic [GW-1:0]       ghr_out,
  output logic [31:0]         perf_branches,
  output logic [31:0]         perf_mispred
);
  logic [1:0] cnt [2**IDX_BITS];
  logic [IDX_BITS-1:0] hist;
  logic upd;
  logic unused_pc;
  assign upd = CE && upd_en;
  assign unused_pc = ^{if_pc[31:IDX_BITS+2], if_pc[1:0]};
  assign pred_idx = if_pc[IDX_BITS+1:2] ^ hist;
  assign pht_out = cnt[pred_idx];
  for (genvar g = 0; g < 2**IDX_BITS; g++) begin : g_cnt
    pht_sat_counter2 #(.INIT_STATE(INIT_STATE)) u_cnt (
      .clk(clk),
      .rst(rst),
      .en(upd && upd_idx == IDX_BITS'(g)),
      .up(upd_taken),
      .q(cnt[g])
    );
  end
  if (GHR_BITS == 0) begin : g_no_ghr
    assign ghr_out = '0;
    assign hist = '0;
  end else begin : g_ghr
    logic [GW-1:0] ghr;
    // shift the resolved outcome into bit0; the new history only affects lookups after the edge
    always_ff @(posedge clk or posedge rst)
      if (rst) ghr <= '0;
      else if (upd) ghr <= GW'({ghr, upd_taken});
    assign ghr_out = ghr;
    assign hist = IDX_BITS'(ghr);
  end
  // saturating resolved-branch and mispredict counts
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_branches <= '0;
      perf_mispred <= '0;
    end else if (upd) begin
      perf_branches <= &perf_branches ? perf_branches : perf_branches + 32'd1;
      if (upd_mispred) perf_mispred <= &perf_mispred ? perf_mispred : perf_mispred + 32'd1;
    end
endmodule
